mdu: RTL and testbench
======================

# mdu

Multiply/divide unit for the five-stage MIPS pipeline, sitting in the E stage beside the ALU. It executes `mult`, `multu`, `div`, `divu` over a fixed multi-cycle latency, holds the HI/LO registers, and services `mthi`/`mtlo` writes. It produces the `busy` condition and the `stallMD` request that the hazard/forwarding unit combines with its own stall terms to freeze PC, hold the F/D register and clear E.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles for `mult`/`multu`, legal range 1–31.
- `DIV_CYCLES`, 10: busy cycles for `div`/`divu`, legal range 1–31.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  E-stage instruction is mult/multu/div/divu; one-cycle pulse.
- `op`  in  2  operation: 0 `mult`, 1 `multu`, 2 `div`, 3 `divu`. Sampled with `start`.
- `A`  in  32  rs operand (forwarded E value).
- `B`  in  32  rt operand (forwarded E value).
- `wHI`  in  1  `mthi` in E.
- `wLO`  in  1  `mtlo` in E.
- `wdata`  in  32  rs value for `mthi`/`mtlo`.
- `mdD`  in  1  D-stage instruction is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- `HI`  out  32  architectural HI; feeds the `mfhi` result mux.
- `LO`  out  32  architectural LO; feeds the `mflo` result mux.
- `busy`  out  1  an operation is in flight.
- `stallMD`  out  1  combinational: `mdD && (start || busy)`.

## Operation
- State: IDLE / RUN. Registers: 5-bit `cnt`, `hiPend`, `loPend`, `HI`, `LO`.
- Reset: `HI=0`, `LO=0`, `busy=0`, `cnt=0`, pending regs = 0, state IDLE. Reset takes priority over every other input, including a reset issued mid-operation. The in-flight result is discarded.
- IDLE + `start`:
  - Compute the result into `hiPend`/`loPend`.
  - Load `cnt` = `MULT_CYCLES` for op 0/1, or `DIV_CYCLES` for op 2/3.
  - Go to RUN.
- Arithmetic:
  - `mult`: 64-bit signed product. `{HI,LO}` = product.
  - `multu`: 64-bit unsigned product.
  - `div`: signed. LO = quotient truncated toward zero; HI = remainder, sign of dividend. `0x80000000 / 0xFFFFFFFF` gives LO=`0x80000000`, HI=0.
  - `divu`: unsigned quotient and remainder.
  - Divide by zero (B=0): pending values equal current HI/LO, so HI/LO are unchanged. Full latency still applies.
- RUN: `cnt` decrements each cycle. On the edge where `cnt==1`, commit HI←`hiPend`, LO←`loPend`, go to IDLE, `cnt=0`.
- `busy` = (state==RUN).
- `mthi`/`mtlo` in IDLE: HI (LO) ← `wdata` at the edge.
- While RUN, `start`, `wHI` and `wLO` are ignored. The hazard unit prevents these via `stallMD`; the bench checks that they are ignored.
- Simultaneous `start` and `wHI`/`wLO` in IDLE: `start` wins and the write is dropped.
- `stallMD` depends on current-cycle `start`, so a D-stage MD instruction stalls in the same cycle its predecessor issues.

## Timing
- `start` sampled at edge t0. Then:
  - `busy=1` for exactly N cycles after t0.
  - HI/LO hold their new values from the edge at t0+N, which is the same edge at which `busy` falls.
- `mfhi`/`mflo` in D is released on the first cycle with `busy=0` and `start=0`. It then reads committed HI/LO in E.
- Back-to-back: a new `start` is accepted in the first IDLE cycle after commit. There is no dead cycle.
- `mthi`/`mtlo` write latency: 1 edge.
- Outputs HI/LO are registered. `busy` is registered. `stallMD` is combinational, with no path from `A`, `B` or `wdata`.

## Test plan
- Signed multiply: `start`, op=0, A=`0xFFFFFFFE` (−2), B=3 → `busy` high 5 cycles; then HI=`0xFFFFFFFF`, LO=`0xFFFFFFFA`. Repeat with op=1 → HI=2, LO=`0xFFFFFFFA`.
- Signed divide: op=2, A=−7, B=2 → `busy` 10 cycles; LO=`0xFFFFFFFD`, HI=`0xFFFFFFFF`. Overflow case A=`0x80000000`, B=−1 → LO=`0x80000000`, HI=0. Divide by zero leaves HI/LO unchanged.
- Stall: `start` at cycle 0 with `mdD=1` held → `stallMD=1` on cycles 0..5 (mult) and 0 on cycle 6. With `mdD=0`, `stallMD` stays 0 throughout.
- Writes: IDLE `wHI=1`, `wdata=0x12345678` → HI=`0x12345678` next cycle. `wLO` during RUN → LO unchanged, and the commit value appears.
- Reset at cycle 3 of a divide → next cycle `busy=0`, HI=LO=0. Nothing is committed afterwards. A new `start` issued immediately completes normally.
- Back-to-back: mult commits, then `start` div the very next cycle → accepted; `busy` high 10 more cycles, with correct final HI/LO.

Source files
------------

// File: rtl/mdu.sv
// Multiply/divide unit for the E stage: fixed-latency mult/multu/div/divu, HI/LO registers,
// mthi/mtlo writes and the MD stall request for the hazard unit.
module mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        wHI,
   input  logic        wLO,
   input  logic [31:0] wdata,
   input  logic        mdD,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        busy,
   output logic        stallMD
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e      stateQ, stateD;
   logic [4:0]  cntQ, cntD;
   logic [31:0] hiQ, hiD, loQ, loD;
   logic [31:0] hiPendQ, hiPendD, loPendQ, loPendD;

   logic        accept, commit;
   logic [31:0] resHi, resLo;
   logic [63:0] prodS, prodU;
   logic [31:0] absA, absB, sDivisor, qMag, rMag, quoS, remS;
   logic [31:0] uDivisor, quoU, remU;

   assign accept = (stateQ == StIdle) && start;
   assign commit = (stateQ == StRun) && (cntQ == 5'd1);

   // Arithmetic results, computed combinationally from the issuing operands.
   always_comb begin
      prodS    = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
      prodU    = {32'd0, A} * {32'd0, B};
      // Signed divide via magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
      absA     = A[31] ? -A : A;
      absB     = B[31] ? -B : B;
      sDivisor = (absB == 32'd0) ? 32'd1 : absB;
      qMag     = absA / sDivisor;
      rMag     = absA % sDivisor;
      quoS     = (A[31] ^ B[31]) ? -qMag : qMag;
      remS     = A[31] ? -rMag : rMag;
      uDivisor = (B == 32'd0) ? 32'd1 : B;
      quoU     = A / uDivisor;
      remU     = A % uDivisor;

      resHi = hiQ;
      resLo = loQ;
      unique case (op)
         2'd0: begin
            resHi = prodS[63:32];
            resLo = prodS[31:0];
         end
         2'd1: begin
            resHi = prodU[63:32];
            resLo = prodU[31:0];
         end
         2'd2: begin
            // Divide by zero keeps HI/LO as they are.
            if (B != 32'd0) begin
               resHi = remS;
               resLo = quoS;
            end
         end
         2'd3: begin
            if (B != 32'd0) begin
               resHi = remU;
               resLo = quoU;
            end
         end
         default: ;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ <= StIdle;
      end else begin
         stateQ <= stateD;
      end
   end

   // Next-state logic.
   always_comb begin
      stateD = stateQ;
      unique case (stateQ)
         StIdle:  if (start) stateD = StRun;
         StRun:   if (cntQ == 5'd1) stateD = StIdle;
         default: stateD = StIdle;
      endcase
   end

   // Outputs.
   always_comb begin
      busy    = (stateQ == StRun);
      stallMD = mdD && (start || (stateQ == StRun));
   end

   // Datapath next values.
   always_comb begin
      cntD    = cntQ;
      hiD     = hiQ;
      loD     = loQ;
      hiPendD = hiPendQ;
      loPendD = loPendQ;
      if (accept) begin
         hiPendD = resHi;
         loPendD = resLo;
         cntD    = op[1] ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
      end else if (commit) begin
         hiD  = hiPendQ;
         loD  = loPendQ;
         cntD = 5'd0;
      end else if (stateQ == StRun) begin
         cntD = cntQ - 5'd1;
      end else begin
         // Idle without start: mthi/mtlo land here; a concurrent start drops them.
         if (wHI) hiD = wdata;
         if (wLO) loD = wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cntQ    <= 5'd0;
         hiQ     <= 32'd0;
         loQ     <= 32'd0;
         hiPendQ <= 32'd0;
         loPendQ <= 32'd0;
      end else begin
         cntQ    <= cntD;
         hiQ     <= hiD;
         loQ     <= loD;
         hiPendQ <= hiPendD;
         loPendQ <= loPendD;
      end
   end

   assign HI = hiQ;
   assign LO = loQ;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: a longint reference model checked every cycle plus literal expectations.
module tb_mdu;

   localparam int unsigned MULT_CYCLES = 5;
   localparam int unsigned DIV_CYCLES  = 10;

   logic        clk = 1'b0;
   logic        reset, start, wHI, wLO, mdD;
   logic [1:0]  op;
   logic [31:0] A, B, wdata;
   logic [31:0] HI, LO;
   logic        busy, stallMD;

   int nPass  = 0;
   int nTotal = 0;
   bit checking = 1'b0;

   mdu #(
      .MULT_CYCLES(MULT_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .A      (A),
      .B      (B),
      .wHI    (wHI),
      .wLO    (wLO),
      .wdata  (wdata),
      .mdD    (mdD),
      .HI     (HI),
      .LO     (LO),
      .busy   (busy),
      .stallMD(stallMD)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nTotal++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: architectural rules in plain arithmetic.
   logic [31:0] mHi, mLo, pHi, pLo;
   int          mLeft;

   task automatic compute(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rh, output logic [31:0] rl);
      longint      sa, sb, q, r;
      logic [63:0] p, uq, ur;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      rh = mHi;
      rl = mLo;
      case (o)
         2'd0: begin p = 64'(sa * sb); rh = p[63:32]; rl = p[31:0]; end
         2'd1: begin p = {32'd0, a} * {32'd0, b}; rh = p[63:32]; rl = p[31:0]; end
         2'd2: if (b != 0) begin
            q = sa / sb; r = sa % sb;
            p = 64'(q); rl = p[31:0];
            p = 64'(r); rh = p[31:0];
         end
         default: if (b != 0) begin
            uq = {32'd0, a} / {32'd0, b}; ur = {32'd0, a} % {32'd0, b};
            rl = uq[31:0]; rh = ur[31:0];
         end
      endcase
   endtask

   always @(posedge clk) begin
      if (reset) begin
         mHi = 0; mLo = 0; mLeft = 0;
      end else if (mLeft > 0) begin
         mLeft--;
         if (mLeft == 0) begin mHi = pHi; mLo = pLo; end
      end else if (start) begin
         compute(op, A, B, pHi, pLo);
         mLeft = op[1] ? DIV_CYCLES : MULT_CYCLES;
      end else begin
         if (wHI) mHi = wdata;
         if (wLO) mLo = wdata;
      end
   end

   // Per-cycle comparison against the model.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (checking) begin
            check("busy", 32'(busy), 32'(mLeft != 0));
            check("HI", HI, mHi);
            check("LO", LO, mLo);
            check("stallMD", 32'(stallMD), 32'(mdD && (start || mLeft != 0)));
         end
      end
   end

   task automatic idleIn();
      start = 0; op = 0; A = 0; B = 0; wHI = 0; wLO = 0; wdata = 0; reset = 0;
   endtask

   // Issue an operation for one cycle, then return at the next negedge.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      idleIn();
      start = 1; op = o; A = a; B = b;
      @(negedge clk);
      idleIn();
   endtask

   // Count busy cycles (bounded) and compare with the expected latency.
   task automatic waitBusy(input string nm, input int expCycles);
      int n = 0;
      while (busy && n < 40) begin
         n++;
         @(negedge clk);
      end
      check(nm, 32'(n), 32'(expCycles));
   endtask

   task automatic expectHL(input string nm, input logic [31:0] h, input logic [31:0] l);
      check({nm, ".HI"}, HI, h);
      check({nm, ".LO"}, LO, l);
   endtask

   initial begin
      idleIn();
      mdD = 0;
      reset = 1;
      @(negedge clk);
      @(negedge clk);
      reset = 0;
      checking = 1;
      expectHL("reset", 32'h0, 32'h0);
      check("reset.busy", 32'(busy), 32'd0);

      issue(2'd0, 32'hFFFF_FFFE, 32'd3);
      waitBusy("mult.lat", 5);
      expectHL("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

      issue(2'd1, 32'hFFFF_FFFE, 32'd3);
      waitBusy("multu.lat", 5);
      expectHL("multu", 32'h2, 32'hFFFF_FFFA);

      issue(2'd2, 32'hFFFF_FFF9, 32'd2);
      waitBusy("div.lat", 10);
      expectHL("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      waitBusy("divovf.lat", 10);
      expectHL("divovf", 32'h0, 32'h8000_0000);

      issue(2'd2, 32'd5, 32'd0);
      waitBusy("div0.lat", 10);
      expectHL("div0", 32'h0, 32'h8000_0000);

      issue(2'd3, 32'd100, 32'd7);
      waitBusy("divu.lat", 10);
      expectHL("divu", 32'd2, 32'd14);

      // Stall window with mdD held: cycles 0..5 stall, cycle 6 releases.
      idleIn();
      mdD = 1; start = 1; op = 2'd0; A = 32'd3; B = 32'd4;
      #1 check("stall.c0", 32'(stallMD), 32'd1);
      @(negedge clk);
      idleIn();
      for (int i = 1; i <= 6; i++) begin
         #1 check("stall.cyc", 32'(stallMD), 32'(i <= 5));
         @(negedge clk);
      end
      mdD = 0;
      expectHL("stallmult", 32'd0, 32'd12);

      wHI = 1; wdata = 32'h1234_5678;
      @(negedge clk);
      idleIn();
      check("mthi", HI, 32'h1234_5678);

      // Writes and starts during RUN are ignored.
      issue(2'd0, 32'd6, 32'd7);
      wLO = 1; wHI = 1; wdata = 32'hDEAD_BEEF; start = 1; op = 2'd3; A = 1; B = 1;
      @(negedge clk);
      @(negedge clk);
      idleIn();
      waitBusy("runwr.lat", 3);
      expectHL("runwr", 32'd0, 32'd42);

      // start beats a simultaneous mthi.
      idleIn();
      start = 1; op = 2'd0; A = 32'd2; B = 32'd2; wHI = 1; wdata = 32'h0000_AAAA;
      @(negedge clk);
      idleIn();
      waitBusy("startwins.lat", 5);
      expectHL("startwins", 32'd0, 32'd4);

      // Reset mid-divide discards the result; a fresh start completes.
      issue(2'd2, 32'd100, 32'd3);
      @(negedge clk);
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      check("rst.busy", 32'(busy), 32'd0);
      expectHL("rst", 32'd0, 32'd0);
      issue(2'd0, 32'd5, 32'd5);
      waitBusy("postrst.lat", 5);
      repeat (12) @(negedge clk);
      expectHL("postrst", 32'd0, 32'd25);

      // Back-to-back: div issued in the first idle cycle after the mult commit.
      issue(2'd0, 32'd7, 32'hFFFF_FFFD);
      waitBusy("b2b.mult.lat", 5);
      expectHL("b2b.mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      issue(2'd2, 32'd1000, 32'hFFFF_FFF9);
      waitBusy("b2b.div.lat", 10);
      expectHL("b2b.div", 32'd6, 32'hFFFF_FF72);

      repeat (2) @(negedge clk);
      checking = 0;
      $display("%0d/%0d checks passed", nPass, nTotal);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
